adc_frame_align: RTL and testbench
==================================

Name: adc_frame_align

Overview:
- Frame-alignment controller for the AD366x-style serial ADC interface: 2 lanes per channel, 16 bit-times per sample, frame (FR) signal high for 8 bit-times and low for 8.
- Watches the deserialized FR word and drives bitslip pulses to the lane deserializers until the FR word equals the expected pattern. It then verifies stable alignment, declares lock and monitors for loss of lock.
- Sits in the ADC clock domain between the deserializer primitives and the housekeeping/status registers.

Parameters:
- FRW, 8, width of the deserialized frame word per fr_vld_i beat.
- FR_PAT, 8'b11110000, expected aligned frame word.
- RST_CYC, 8, clk_i cycles ser_rst_o is held high at start of training.
- SETTLE_N, 4, valid words discarded after a deserializer reset or bitslip.
- VERIFY_N, 16, consecutive matching valid words required for lock.
- MISS_MAX, 3, consecutive mismatching valid words in LOCKED that declare loss.

Ports:
- clk_i, in, 1, ADC-domain clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, single-cycle request to (re)start training.
- fr_word_i, in, FRW, deserialized frame word.
- fr_vld_i, in, 1, fr_word_i valid this cycle.
- ser_rst_o, out, 1, deserializer reset.
- bitslip_o, out, 1, one-cycle bitslip pulse to all lane deserializers.
- busy_o, out, 1, training in progress.
- locked_o, out, 1, alignment verified.
- err_o, out, 1, alignment failed; sticky until start_i or rst_i.
- lost_o, out, 1, lock was lost; sticky until start_i or rst_i.
- slip_cnt_o, out, $clog2(FRW)+1, bitslips issued in the current attempt.

Behaviour:
- Reset: rst_i is synchronous and active-high and overrides everything, including mid-training. All outputs are 0, the FSM goes to IDLE and all counters are cleared.
- Counting rule: only cycles with fr_vld_i=1 advance the SETTLE, CHECK, VERIFY and LOCKED word counters. Cycles with fr_vld_i=0 are ignored.
- States: IDLE, SER_RST, SETTLE, CHECK, SLIP, VERIFY, LOCKED, ERROR.
- IDLE:
  - start_i -> SER_RST.
  - On entry to SER_RST: clear err_o, lost_o and slip_cnt_o; set busy_o=1.
- SER_RST:
  - ser_rst_o=1 for exactly RST_CYC cycles.
  - Then -> SETTLE with the settle counter cleared.
- SETTLE: after SETTLE_N valid words -> CHECK.
- CHECK, on the next valid word:
  - If fr_word_i==FR_PAT -> VERIFY with the match count set to 1.
  - Else if slip_cnt_o==FRW-1 -> ERROR.
  - Else -> SLIP.
- SLIP:
  - Exactly one cycle: bitslip_o=1 and slip_cnt_o increments.
  - Then -> SETTLE.
  - bitslip_o is never high in two consecutive cycles.
- VERIFY:
  - A matching valid word increments the match count.
  - When the count reaches VERIFY_N -> LOCKED: locked_o=1, busy_o=0.
  - A mismatch -> SLIP, or -> ERROR if slip_cnt_o==FRW-1.
- LOCKED:
  - A mismatching valid word increments the miss count; a matching word clears it.
  - When the miss count reaches MISS_MAX: lost_o=1, locked_o=0, busy_o=1, slip_cnt_o cleared, -> SETTLE (realign without deserializer reset).
- ERROR:
  - err_o=1, busy_o=0, locked_o=0.
  - Waits for start_i.
- start_i handling:
  - In IDLE, LOCKED or ERROR: start_i -> SER_RST (a restart clears lost_o and err_o).
  - In any other state: start_i is ignored.
- Latency: lock occurs at the earliest RST_CYC + 1 cycles plus SETTLE_N + VERIFY_N valid words after start_i.
- Timing: all outputs are registered and change only on clk_i.

Test Plan:
- Already aligned: FR_PAT on every beat, fr_vld_i=1 continuously, start_i pulse. Required: ser_rst_o high 8 cycles, no bitslip_o, locked_o=1 after 20 valid words, slip_cnt_o=0.
- Misaligned by 3: bench rotates the FR word left by one per bitslip_o, starting at 3 rotations off. Required: exactly 3 bitslip_o pulses separated by ≥SETTLE_N valid words, then locked_o=1 with slip_cnt_o=3.
- Never matching: constant 8'h00. Required: 7 bitslip_o pulses, then err_o=1, busy_o=0, locked_o=0; a later start_i clears err_o.
- Lock loss: after lock, inject 2 mismatching beats then FR_PAT, so locked_o stays 1. Then inject 3 consecutive mismatches: lost_o=1, locked_o=0, realignment starts without ser_rst_o.
- Valid gating: toggle fr_vld_i 1-of-3 during VERIFY. Required: lock after 16 valid matching words regardless of idle cycles; a mismatch on an invalid cycle has no effect.
- Reset mid-operation: assert rst_i during SLIP and then during VERIFY. Required: next cycle all outputs 0, FSM IDLE; start_i retrains normally.

Source files
------------

// File: rtl/adc_frame_align.sv
// adc_frame_align: bitslips the ADC lane deserializers until the frame word matches FR_PAT, then verifies and monitors lock
module adc_frame_align #(
  parameter int             FRW      = 8,
  parameter logic [FRW-1:0] FR_PAT   = 8'b11110000,
  parameter int             RST_CYC  = 8,
  parameter int             SETTLE_N = 4,
  parameter int             VERIFY_N = 16,
  parameter int             MISS_MAX = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [FRW-1:0]         fr_word_i,
  input  logic                   fr_vld_i,
  output logic                   ser_rst_o,
  output logic                   bitslip_o,
  output logic                   busy_o,
  output logic                   locked_o,
  output logic                   err_o,
  output logic                   lost_o,
  output logic [$clog2(FRW):0]   slip_cnt_o
);
  localparam int M1 = RST_CYC > SETTLE_N ? RST_CYC : SETTLE_N;
  localparam int M2 = VERIFY_N > MISS_MAX ? VERIFY_N : MISS_MAX;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  localparam int SW = $clog2(FRW) + 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_N - 1);
  localparam logic [CW-1:0] VER_LAST  = CW'(VERIFY_N - 1);
  localparam logic [CW-1:0] MISS_LAST = CW'(MISS_MAX - 1);
  localparam logic [SW-1:0] SLIP_MAX  = SW'(FRW - 1);
  typedef enum logic [2:0] {IDLE, SER_RST, SETTLE, CHECK, SLIP, VERIFY, LOCKED, ERROR} state_t;
  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [SW-1:0] w_slip;
  logic          w_lost, w_match, w_slip_max, w_enter;
  assign w_match    = fr_word_i == FR_PAT;
  assign w_slip_max = slip_cnt_o == SLIP_MAX;
  assign w_enter    = w_nxt != r_state;
  // outputs are registered from the next state so they line up with the state change
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      ser_rst_o  <= 1'b0;
      bitslip_o  <= 1'b0;
      busy_o     <= 1'b0;
      locked_o   <= 1'b0;
      err_o      <= 1'b0;
      lost_o     <= 1'b0;
      slip_cnt_o <= '0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt;
      ser_rst_o  <= w_nxt == SER_RST;
      bitslip_o  <= w_nxt == SLIP;
      busy_o     <= w_nxt inside {SER_RST, SETTLE, CHECK, SLIP, VERIFY};
      locked_o   <= w_nxt == LOCKED;
      err_o      <= w_nxt == ERROR;
      lost_o     <= w_lost;
      slip_cnt_o <= w_slip;
    end
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE, ERROR: w_nxt = start_i ? SER_RST : r_state;
      SER_RST:     w_nxt = r_cnt == RST_LAST ? SETTLE : SER_RST;
      SETTLE:      w_nxt = fr_vld_i && r_cnt == SET_LAST ? CHECK : SETTLE;
      CHECK:       if (fr_vld_i) w_nxt = w_match ? VERIFY : w_slip_max ? ERROR : SLIP;
      SLIP:        w_nxt = SETTLE;
      VERIFY:      if (fr_vld_i) w_nxt = !w_match ? (w_slip_max ? ERROR : SLIP) : r_cnt == VER_LAST ? LOCKED : VERIFY;
      LOCKED:      w_nxt = start_i ? SER_RST : fr_vld_i && !w_match && r_cnt == MISS_LAST ? SETTLE : LOCKED;
      default:     w_nxt = IDLE;
    endcase
  end
  // one shared counter: reset cycles, settle words, match count, miss count
  always_comb begin
    w_cnt = r_cnt;
    if (w_enter)
      w_cnt = w_nxt == VERIFY ? ONE : '0;
    else if (r_state == SER_RST || (fr_vld_i && r_state inside {SETTLE, VERIFY}))
      w_cnt = r_cnt + ONE;
    else if (fr_vld_i && r_state == LOCKED)
      w_cnt = w_match ? '0 : r_cnt + ONE;
    w_slip = w_nxt == SLIP ? slip_cnt_o + SW'(1)
           : (w_enter && w_nxt == SER_RST) || (r_state == LOCKED && w_nxt == SETTLE) ? '0
           : slip_cnt_o;
    w_lost = w_enter && w_nxt == SER_RST ? 1'b0
           : r_state == LOCKED && w_nxt == SETTLE ? 1'b1
           : lost_o;
  end
endmodule

// File: tb/tb_adc_frame_align.sv
// tb_adc_frame_align: rotating-frame ADC model with a bitslip scoreboard and per-scenario checks
module tb_adc_frame_align;
  localparam logic [7:0] PAT = 8'b11110000;
  logic       clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, fr_vld_i = 1'b1;
  logic [7:0] fr_word_i;
  logic       ser_rst_o, bitslip_o, busy_o, locked_o, err_o, lost_o;
  logic [3:0] slip_cnt_o;
  logic [9:0] all_o;
  int         n_cmp = 0, n_err = 0;
  int         off = 0;
  bit         bad = 1'b0;
  logic [7:0] bad_word = 8'h00;
  int         sb[$];
  int         vcnt = 0;
  bit         have_prev = 1'b0, prev_bs = 1'b0;
  always #5 clk_i = ~clk_i;
  function automatic logic [7:0] rotl(input logic [7:0] p, input int k);
    logic [15:0] t;
    t = {p, p} << k;
    return t[15:8];
  endfunction
  assign fr_word_i = bad ? bad_word : rotl(PAT, off);
  assign all_o = {ser_rst_o, bitslip_o, busy_o, locked_o, err_o, lost_o, slip_cnt_o};
  adc_frame_align dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .fr_word_i(fr_word_i), .fr_vld_i(fr_vld_i),
    .ser_rst_o(ser_rst_o), .bitslip_o(bitslip_o), .busy_o(busy_o), .locked_o(locked_o),
    .err_o(err_o), .lost_o(lost_o), .slip_cnt_o(slip_cnt_o)
  );
  // each bitslip pops the expected slip count and rotates the modelled frame one bit left
  always @(posedge clk_i) begin
    int e;
    #1;
    if (rst_i) begin
      vcnt = 0; have_prev = 1'b0; prev_bs = 1'b0;
    end else if (bitslip_o) begin
      n_cmp++;
      if (prev_bs) begin n_err++; $display("FAIL bitslip_spacing: bitslip_o high two cycles running"); end
      if (have_prev) begin
        n_cmp++;
        if (vcnt < 4) begin n_err++; $display("FAIL bitslip_gap: got %0d valid words, need >= 4", vcnt); end
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++; $display("FAIL bitslip_unexpected: slip_cnt_o=%0d, none expected", slip_cnt_o);
      end else begin
        e = sb.pop_front();
        if (slip_cnt_o !== 4'(e)) begin n_err++; $display("FAIL bitslip_cnt: got %0d want %0d", slip_cnt_o, e); end
      end
      off = (off + 1) % 8; vcnt = 0; have_prev = 1'b1; prev_bs = 1'b1;
    end else begin
      prev_bs = 1'b0;
      if (fr_vld_i) vcnt++;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask
  task automatic pulse_start(input int o);
    @(negedge clk_i); start_i = 1'b1; off = o;
    @(negedge clk_i); start_i = 1'b0;
  endtask
  task automatic count_ser_rst(output int c);
    c = 0;
    while (ser_rst_o && c < 50) begin c++; @(negedge clk_i); end
  endtask
  task automatic wait_lock(input int budget, output int c);
    c = 0;
    while (!locked_o && c < budget) begin @(negedge clk_i); c++; end
  endtask
  task automatic test_reset();
    rst_i = 1'b1; bad = 1'b0; off = 0; fr_vld_i = 1'b1;
    tick(3);
    n_cmp++;
    if (all_o !== 10'd0) begin n_err++; $display("FAIL reset_outputs: got %b want 0", all_o); end
    rst_i = 1'b0;
    tick(5);
    n_cmp++;
    if (all_o !== 10'd0) begin n_err++; $display("FAIL idle_outputs: got %b want 0", all_o); end
  endtask
  task automatic test_aligned();
    int c;
    pulse_start(0);
    n_cmp++;
    if ({ser_rst_o, busy_o} !== 2'b11) begin n_err++; $display("FAIL start_busy: got %b want 11", {ser_rst_o, busy_o}); end
    count_ser_rst(c);
    n_cmp++;
    if (c != 8) begin n_err++; $display("FAIL ser_rst_len: got %0d want 8", c); end
    wait_lock(100, c);
    n_cmp++;
    if (c != 20) begin n_err++; $display("FAIL aligned_lock_words: got %0d want 20", c); end
    n_cmp++;
    if ({slip_cnt_o, busy_o, locked_o} !== {4'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL aligned_state: got %b want 000001", {slip_cnt_o, busy_o, locked_o});
    end
  endtask
  task automatic test_misaligned();
    int c;
    sb = {1, 2, 3};
    pulse_start(5);
    count_ser_rst(c);
    wait_lock(600, c);
    n_cmp++;
    if ({locked_o, slip_cnt_o} !== {1'b1, 4'd3}) begin n_err++; $display("FAIL mis3_lock: got %b want 10011", {locked_o, slip_cnt_o}); end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL mis3_pulses: %0d expected bitslips missing", sb.size()); end
  endtask
  task automatic test_never_match();
    int c;
    sb = {1, 2, 3, 4, 5, 6, 7};
    bad = 1'b1; bad_word = 8'h00;
    pulse_start(0);
    c = 0;
    while (!err_o && c < 600) begin @(negedge clk_i); c++; end
    n_cmp++;
    if ({err_o, busy_o, locked_o, slip_cnt_o} !== {3'b100, 4'd7}) begin
      n_err++; $display("FAIL nomatch_err: got %b want 1000111", {err_o, busy_o, locked_o, slip_cnt_o});
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL nomatch_pulses: %0d expected bitslips missing", sb.size()); end
    tick(10);
    n_cmp++;
    if ({err_o, busy_o} !== 2'b10) begin n_err++; $display("FAIL err_sticky: got %b want 10", {err_o, busy_o}); end
    bad = 1'b0;
    pulse_start(0);
    n_cmp++;
    if ({err_o, busy_o, ser_rst_o} !== 3'b011) begin n_err++; $display("FAIL err_clear: got %b want 011", {err_o, busy_o, ser_rst_o}); end
    count_ser_rst(c);
    wait_lock(100, c);
    n_cmp++;
    if (c != 20) begin n_err++; $display("FAIL relock_after_err: got %0d want 20", c); end
  endtask
  task automatic test_lock_loss();
    int c;
    bit sr;
    bad_word = 8'h0F;
    repeat (2) begin
      bad = 1'b1; tick(2);
      bad = 1'b0; tick(1);
    end
    n_cmp++;
    if ({locked_o, lost_o, busy_o} !== 3'b100) begin n_err++; $display("FAIL miss2_hold: got %b want 100", {locked_o, lost_o, busy_o}); end
    bad = 1'b1; tick(3);
    bad = 1'b0;
    n_cmp++;
    if ({lost_o, locked_o, busy_o, ser_rst_o, slip_cnt_o} !== {4'b1010, 4'd0}) begin
      n_err++; $display("FAIL lost_detect: got %b want 10100000", {lost_o, locked_o, busy_o, ser_rst_o, slip_cnt_o});
    end
    c = 0; sr = 1'b0;
    while (!locked_o && c < 100) begin @(negedge clk_i); c++; sr |= ser_rst_o; end
    n_cmp++;
    if ({c == 20, sr, lost_o} !== 3'b101) begin
      n_err++; $display("FAIL realign: words=%0d ser_rst_seen=%0b lost=%0b want 20/0/1", c, sr, lost_o);
    end
    pulse_start(0);
    n_cmp++;
    if (lost_o !== 1'b0) begin n_err++; $display("FAIL lost_clear: got %b want 0", lost_o); end
    count_ser_rst(c);
    wait_lock(100, c);
  endtask
  task automatic test_valid_gating();
    int k, nv;
    bad_word = 8'h0F;
    @(negedge clk_i); start_i = 1'b1; fr_vld_i = 1'b0; off = 0;
    @(negedge clk_i); start_i = 1'b0;
    k = 0; nv = 0;
    while (!locked_o && k < 400) begin
      fr_vld_i = (k % 3 == 0);
      bad = !fr_vld_i;
      if (fr_vld_i && !ser_rst_o) nv++;
      @(negedge clk_i);
      k++;
    end
    n_cmp++;
    if ({locked_o, nv == 20} !== 2'b11) begin n_err++; $display("FAIL gated_lock: locked=%0b words=%0d want 1/20", locked_o, nv); end
    fr_vld_i = 1'b0; bad = 1'b1;
    tick(5);
    n_cmp++;
    if ({locked_o, lost_o} !== 2'b10) begin n_err++; $display("FAIL invalid_ignored: got %b want 10", {locked_o, lost_o}); end
    fr_vld_i = 1'b1; bad = 1'b0;
    tick(2);
  endtask
  task automatic test_reset_mid();
    int c;
    sb = {1};
    pulse_start(5);
    c = 0;
    while (!bitslip_o && c < 200) begin @(negedge clk_i); c++; end
    n_cmp++;
    if (bitslip_o !== 1'b1) begin n_err++; $display("FAIL reach_slip: got %b want 1", bitslip_o); end
    rst_i = 1'b1; tick(1);
    n_cmp++;
    if (all_o !== 10'd0) begin n_err++; $display("FAIL rst_in_slip: got %b want 0", all_o); end
    rst_i = 1'b0; sb.delete(); tick(5);
    n_cmp++;
    if (all_o !== 10'd0) begin n_err++; $display("FAIL idle_after_slip_rst: got %b want 0", all_o); end
    sb = {1, 2, 3};
    pulse_start(5);
    count_ser_rst(c);
    n_cmp++;
    if (c != 8) begin n_err++; $display("FAIL retrain_ser_rst: got %0d want 8", c); end
    wait_lock(600, c);
    n_cmp++;
    if ({locked_o, slip_cnt_o, sb.size() == 0} !== {1'b1, 4'd3, 1'b1}) begin
      n_err++; $display("FAIL retrain_lock: locked=%0b slip=%0d pending=%0d want 1/3/0", locked_o, slip_cnt_o, sb.size());
    end
    pulse_start(0);
    count_ser_rst(c);
    tick(10);
    rst_i = 1'b1; tick(1);
    n_cmp++;
    if (all_o !== 10'd0) begin n_err++; $display("FAIL rst_in_verify: got %b want 0", all_o); end
    rst_i = 1'b0; tick(30);
    n_cmp++;
    if (all_o !== 10'd0) begin n_err++; $display("FAIL idle_after_verify_rst: got %b want 0", all_o); end
    pulse_start(0);
    count_ser_rst(c);
    wait_lock(100, c);
    n_cmp++;
    if (c != 20) begin n_err++; $display("FAIL retrain_after_verify_rst: got %0d want 20", c); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_never_match();
    test_lock_loss();
    test_valid_gating();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d entries left", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
